motion_step_controller: RTL
===========================

# motion_step_controller

Two-axis step/direction sequencer that sits between the processor's motor registers (x/y speed and direction) and the stepper driver pins. It also serves the board's four pushbuttons. It arbitrates ownership of both axes between the CPU and manual button control, and generates step pulses at a programmed period. It enforces a direction-setup delay before any step after a direction change, and keeps a signed 32-bit position count per axis that the CPU can read back.

## Interface
- STEP_HIGH_CYC, 100: step pulse high time in clock cycles (≥1).
- DIR_SETUP_CYC, 500: cycles the dir pin must be stable before the first step after a direction change (≥1).
- MANUAL_PERIOD, 100000: step period in cycles under manual control.
- MIN_PERIOD, 2*STEP_HIGH_CYC: smallest permitted step period; shorter requests are clamped to it.
- clock  in  1  system clock (100 MHz); all state changes on its rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- manual_en  in  1  asynchronous switch input; 1 requests manual (button) ownership, 0 requests CPU ownership.
- btn_up, btn_down, btn_left, btn_right  in  1 each  asynchronous pushbuttons.
- cpu_x_speed, cpu_y_speed  in  32  CPU step period in cycles; 0 = stop.
- cpu_x_dir, cpu_y_dir  in  32  CPU direction; only bit 0 is used; 1 = negative (left / up), 0 = positive (right / down).
- x_step, y_step  out  1  step pulse to driver.
- x_dir, y_dir  out  1  direction pin to driver.
- x_pos, y_pos  out  32  signed position in steps.
- x_busy, y_busy  out  1  axis not in IDLE.
- owner_manual  out  1  1 = buttons own both axes, 0 = CPU owns.

## Operation
- manual_en and all four buttons pass through 2-flop synchronizers (reset to 0). CPU inputs are used directly.
- Request per axis, from the current owner:
  - CPU: request when speed≠0; dir = bit 0; period = max(speed, MIN_PERIOD).
  - Manual X: left-only gives dir=1; right-only gives dir=0; both or neither gives no request. Y works the same with up=1 and down=0. Period = max(MANUAL_PERIOD, MIN_PERIOD).
- Axis FSM: IDLE, SETTLE, STEP_HIGH, STEP_LOW.
  - IDLE, request with dir == x_dir: go to STEP_HIGH. Period is latched on entry.
  - IDLE, request with dir ≠ x_dir: update x_dir on the same edge and go to SETTLE.
  - SETTLE: hold for DIR_SETUP_CYC cycles, then STEP_HIGH.
  - SETTLE, request withdrawn or ownership switch pending: return to IDLE with no step issued. x_dir keeps its new value.
  - STEP_HIGH: x_step=1 for STEP_HIGH_CYC cycles, then STEP_LOW.
  - STEP_LOW: x_step=0 for (latched period − STEP_HIGH_CYC) cycles.
  - At the end of STEP_LOW, evaluate the request as in IDLE. Same dir: go straight to STEP_HIGH, so rising edges are exactly period apart. Different dir: go to SETTLE. No request: go to IDLE.
- Changes to speed or dir during a step take effect only at the next decision point. A pulse already in progress is never shortened or stretched.
- Position updates on the edge that raises x_step: dir=0 adds 1, dir=1 subtracts 1. Arithmetic is two's-complement modulo 2^32, so 0x7FFFFFFF+1 wraps to 0x80000000 and 0−1 wraps to 0xFFFFFFFF.
- Ownership arbiter:
  - A switch is pending when the synchronized manual_en ≠ owner_manual.
  - While pending, axes issue no new steps. An in-flight step completes its STEP_LOW, and SETTLE aborts.
  - owner_manual flips on the first edge where pending holds and both axes are IDLE.
  - The new owner's requests are honoured from the following cycle.
- Y axis is identical and independent except for the shared owner.

## Timing
- Reset values:
  - Outputs: x_step, y_step, x_dir, y_dir, x_busy, y_busy, owner_manual all 0; x_pos and y_pos 0.
  - FSMs in IDLE.
  - Reset mid-pulse drops step to 0 asynchronously.
- CPU request with matching dir: x_step rises 1 cycle after the request is first seen in IDLE.
- CPU request with a dir change: x_dir changes 1 cycle after the request; x_step rises DIR_SETUP_CYC cycles after x_dir changes.
- Button input to first effect: +2 cycles for synchronization.
- busy is registered and matches the FSM state: high from the cycle it leaves IDLE until the cycle it re-enters IDLE.

## Test plan
Parameters for all scenarios: STEP_HIGH_CYC=4, DIR_SETUP_CYC=8, MANUAL_PERIOD=20, MIN_PERIOD=8.
1. Steady CPU motion: reset, then cpu_x_speed=12, cpu_x_dir=0 → first x_step rise 1 cycle later. Rises every 12 cycles, each 4 cycles high. x_pos=5 after the 5th rise; x_dir stays 0.
2. Clamp and direction change: cpu_y_speed=3, cpu_y_dir=1 → y_dir=1 after 1 cycle and first y_step 8 cycles later. Steps every 8 cycles; y_pos goes 0xFFFFFFFF, 0xFFFFFFFE, …
3. Mid-step update: set speed 12→16 on the cycle after an x_step rise → that step's rise-to-rise interval is still 12; the next one is 16. Setting speed=0 during STEP_HIGH still completes the full 4-high / 8-low step, then x_busy=0.
4. Ownership handover: CPU stepping X at period 12, raise manual_en mid-STEP_HIGH → no new step is issued and the current step completes. owner_manual=1 the edge after both axes are IDLE. Holding btn_left then gives x_dir=1 and steps every 20 cycles.
5. Manual conflicts: btn_left and btn_right both held → no steps. Release btn_right → steps begin after 2 sync cycles plus the settle time if x_dir changed.
6. Reset mid-operation and wrap: preload x_pos to 0x7FFFFFFF by stepping, then step once more → x_pos=0x80000000. Assert reset during STEP_HIGH → x_step=0 immediately, all outputs return to their reset values, owner_manual=0.

Source files
------------

// File: rtl/motion_step_controller.sv
// Two-axis step/direction sequencer with CPU/pushbutton ownership arbitration.
// motion_step_axis runs one axis; motion_step_controller synchronizes inputs, arbitrates and muxes requests.

module motion_step_axis #(
    parameter int unsigned STEP_HIGH_CYC = 100,
    parameter int unsigned DIR_SETUP_CYC = 500
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_i,
    input  logic        reqDir_i,
    input  logic [31:0] reqPeriod_i,
    output logic        step_o,
    output logic        dir_o,
    output logic        busy_o,
    output logic [31:0] pos_o
);
    typedef enum logic [1:0] {IDLE, SETTLE, STEP_HIGH, STEP_LOW} axisState_e;

    localparam logic [31:0] HighCyc   = 32'(STEP_HIGH_CYC);
    localparam logic [31:0] HighLast  = 32'(STEP_HIGH_CYC - 1);
    localparam logic [31:0] SetupLast = 32'(DIR_SETUP_CYC - 1);

    axisState_e  state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] period_q, period_d;
    logic [31:0] pos_q, pos_d;
    logic        dir_q, dir_d;
    logic        step_q, busy_q;
    logic        decide;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + 32'd1;
        period_d = period_q;
        pos_d    = pos_q;
        dir_d    = dir_q;
        decide   = 1'b0;

        case (state_q)
            IDLE: decide = 1'b1;
            SETTLE: begin
                if (!req_i) begin
                    state_d = IDLE;
                end else if (reqDir_i != dir_q) begin
                    dir_d = reqDir_i;
                    cnt_d = '0;
                end else if (cnt_q == SetupLast) begin
                    state_d  = STEP_HIGH;
                    cnt_d    = '0;
                    period_d = reqPeriod_i;
                end
            end
            STEP_HIGH: begin
                if (cnt_q == HighLast) begin
                    state_d = STEP_LOW;
                    cnt_d   = '0;
                end
            end
            STEP_LOW: begin
                if (cnt_q == period_q - HighCyc - 32'd1) begin
                    decide = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // IDLE and the last STEP_LOW cycle share one decision point so back-to-back rises stay exactly one period apart.
        if (decide) begin
            cnt_d   = '0;
            state_d = IDLE;
            if (req_i && (reqDir_i == dir_q)) begin
                state_d  = STEP_HIGH;
                period_d = reqPeriod_i;
            end else if (req_i) begin
                state_d = SETTLE;
                dir_d   = reqDir_i;
            end
        end

        if ((state_d == STEP_HIGH) && (state_q != STEP_HIGH)) begin
            pos_d = dir_q ? (pos_q - 32'd1) : (pos_q + 32'd1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            period_q <= '0;
            pos_q    <= '0;
            dir_q    <= 1'b0;
            step_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            period_q <= period_d;
            pos_q    <= pos_d;
            dir_q    <= dir_d;
            step_q   <= (state_d == STEP_HIGH);
            busy_q   <= (state_d != IDLE);
        end
    end

    assign step_o = step_q;
    assign dir_o  = dir_q;
    assign busy_o = busy_q;
    assign pos_o  = pos_q;
endmodule

module motion_step_controller #(
    parameter int unsigned STEP_HIGH_CYC = 100,
    parameter int unsigned DIR_SETUP_CYC = 500,
    parameter int unsigned MANUAL_PERIOD = 100000,
    parameter int unsigned MIN_PERIOD    = 2 * STEP_HIGH_CYC
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        manual_en,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic [31:0] cpu_x_speed,
    input  logic [31:0] cpu_y_speed,
    input  logic [31:0] cpu_x_dir,
    input  logic [31:0] cpu_y_dir,
    output logic        x_step,
    output logic        y_step,
    output logic        x_dir,
    output logic        y_dir,
    output logic [31:0] x_pos,
    output logic [31:0] y_pos,
    output logic        x_busy,
    output logic        y_busy,
    output logic        owner_manual
);
    localparam logic [31:0] MinPeriod    = 32'(MIN_PERIOD);
    localparam logic [31:0] ManualPeriod = (MANUAL_PERIOD > MIN_PERIOD) ? 32'(MANUAL_PERIOD) : 32'(MIN_PERIOD);

    logic [4:0]  syncMeta_q, syncOut_q;
    logic        manSync, upSync, downSync, leftSync, rightSync;
    logic        owner_q, owner_d;
    logic        pending;
    logic        xReq, yReq, xReqDir, yReqDir;
    logic [31:0] xPeriod, yPeriod;
    logic        unusedDirBits;

    assign {manSync, upSync, downSync, leftSync, rightSync} = syncOut_q;
    assign pending       = (manSync != owner_q);
    assign unusedDirBits = ^{cpu_x_dir[31:1], cpu_y_dir[31:1]};

    // Ownership only changes once both axes have drained back to IDLE.
    always_comb begin
        owner_d = owner_q;
        if (pending && !x_busy && !y_busy) begin
            owner_d = manSync;
        end
    end

    always_comb begin
        xReq    = 1'b0;
        yReq    = 1'b0;
        xReqDir = 1'b0;
        yReqDir = 1'b0;
        xPeriod = MinPeriod;
        yPeriod = MinPeriod;
        if (!pending) begin
            if (owner_q) begin
                xReq    = leftSync ^ rightSync;
                xReqDir = leftSync;
                xPeriod = ManualPeriod;
                yReq    = upSync ^ downSync;
                yReqDir = upSync;
                yPeriod = ManualPeriod;
            end else begin
                xReq    = (cpu_x_speed != 32'd0);
                xReqDir = cpu_x_dir[0];
                xPeriod = (cpu_x_speed < MinPeriod) ? MinPeriod : cpu_x_speed;
                yReq    = (cpu_y_speed != 32'd0);
                yReqDir = cpu_y_dir[0];
                yPeriod = (cpu_y_speed < MinPeriod) ? MinPeriod : cpu_y_speed;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            syncMeta_q <= '0;
            syncOut_q  <= '0;
            owner_q    <= 1'b0;
        end else begin
            syncMeta_q <= {manual_en, btn_up, btn_down, btn_left, btn_right};
            syncOut_q  <= syncMeta_q;
            owner_q    <= owner_d;
        end
    end

    motion_step_axis #(
        .STEP_HIGH_CYC(STEP_HIGH_CYC),
        .DIR_SETUP_CYC(DIR_SETUP_CYC)
    ) xAxis (
        .clock      (clock),
        .reset      (reset),
        .req_i      (xReq),
        .reqDir_i   (xReqDir),
        .reqPeriod_i(xPeriod),
        .step_o     (x_step),
        .dir_o      (x_dir),
        .busy_o     (x_busy),
        .pos_o      (x_pos)
    );

    motion_step_axis #(
        .STEP_HIGH_CYC(STEP_HIGH_CYC),
        .DIR_SETUP_CYC(DIR_SETUP_CYC)
    ) yAxis (
        .clock      (clock),
        .reset      (reset),
        .req_i      (yReq),
        .reqDir_i   (yReqDir),
        .reqPeriod_i(yPeriod),
        .step_o     (y_step),
        .dir_o      (y_dir),
        .busy_o     (y_busy),
        .pos_o      (y_pos)
    );

    assign owner_manual = owner_q;
endmodule
